// File: rtl/serial_add_sub32.sv
// Bit-serial WIDTH-bit adder/subtractor: one full adder plus a carry flop, LSB first.
// Optional macro OVERFLOW_FLAG_EN adds a registered signed-overflow output V.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

module serial_add_sub32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             BUSY,
`ifdef OVERFLOW_FLAG_EN
  output logic             V,
`endif
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sha_q;
  logic [WIDTH-1:0] shb_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             c_q;
  logic [6:0]       cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  full_adder u_fa (
    .a_i  (sha_q[0]),
    .b_i  (shb_q[0]),
    .ci_i (c_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign last  = (cnt_q == 7'(WIDTH - 1));
  assign sum_d = (sum_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      Y       <= '0;
      CO      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      V       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            sha_q   <= A;
            shb_q   <= SnA ? ~B : B;
            c_q     <= SnA;
            cnt_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q <= sum_d;
          c_q   <= fa_co;
          sha_q <= sha_q >> 1;
          shb_q <= shb_q >> 1;
          cnt_q <= cnt_q + 7'd1;
          if (last) begin
            Y       <= sum_d;
            CO      <= fa_co;
`ifdef OVERFLOW_FLAG_EN
            // c_q here is the carry into the MSB position
            V       <= c_q ^ fa_co;
`endif
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          DONE    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub32.sv
// Directed bench for serial_add_sub32 with a result scoreboard.
// Checks V too when OVERFLOW_FLAG_EN is defined.

module tb_serial_add_sub32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        SnA = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Y;
  logic        CO;
  logic        BUSY;
  logic        DONE;
`ifdef OVERFLOW_FLAG_EN
  logic        V;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] y;
    logic        co;
    logic        v;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] last_y = '0;

  always #5 CLK = ~CLK;

  serial_add_sub32 #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SnA   (SnA),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .CO    (CO),
    .BUSY  (BUSY),
`ifdef OVERFLOW_FLAG_EN
    .V     (V),
`endif
    .DONE  (DONE)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sna);
    logic [32:0] r;
    exp_t e;
    r = {1'b0, a} + {1'b0, (sna ? ~b : b)} + 33'(sna);
    e.y  = r[31:0];
    e.co = r[32];
    if (sna) e.v = (a[31] != b[31]) && (r[31] != a[31]);
    else     e.v = (a[31] == b[31]) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sna);
    A = a;
    B = b;
    SnA = sna;
    START = 1'b1;
    sbq.push_back(model(a, b, sna));
  endtask

  task automatic finish_op(input string tag);
    int n;
    bit ok;
    exp_t e;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (DONE === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (BUSY === 1'b1) n++;
      @(negedge CLK);
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_busy_in_done"}, 64'(BUSY), 64'd0);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_y"}, 64'(Y), 64'(e.y));
      chk({tag, "_co"}, 64'(CO), 64'(e.co));
`ifdef OVERFLOW_FLAG_EN
      chk({tag, "_v"}, 64'(V), 64'(e.v));
`endif
      last_y = e.y;
    end
    @(negedge CLK);
    chk({tag, "_done_pulse_end"}, 64'(DONE), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic sna);
    start_op(a, b, sna);
    @(negedge CLK);
    START = 1'b0;
    chk({tag, "_busy_start"}, 64'(BUSY), 64'd1);
    chk({tag, "_y_hold"}, 64'(Y), 64'(last_y));
    finish_op(tag);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_y", 64'(Y), 64'd0);
    chk("rst_co", 64'(CO), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_v", 64'(V), 64'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;

    run_op("add5p3", 32'd5, 32'd3, 1'b0);
    run_op("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub10m3", 32'd10, 32'd3, 1'b1);
    run_op("sub3m10", 32'd3, 32'd10, 1'b1);
    run_op("subeq", 32'h1234_5678, 32'h1234_5678, 1'b1);

    // START held high; operands changed after capture
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(negedge CLK);
    chk("hold_busy_start", 64'(BUSY), 64'd1);
    A = 32'hAAAA_AAAA;
    finish_op("hold_first");
    chk("hold_idle_busy", 64'(BUSY), 64'd0);
    sbq.push_back(model(32'hAAAA_AAAA, 32'h2222_2222, 1'b0));
    @(negedge CLK);
    chk("hold_second_busy", 64'(BUSY), 64'd1);
    START = 1'b0;
    finish_op("hold_second");

    // reset in the middle of RUN
    A = 32'h1234_5678;
    B = 32'd1;
    SnA = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (16) @(negedge CLK);
    chk("mid_busy", 64'(BUSY), 64'd1);
    RST = 1'b0;
    #1;
    chk("abort_y", 64'(Y), 64'd0);
    chk("abort_co", 64'(CO), 64'd0);
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    last_y = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_no_done", 64'(DONE), 64'd0);
    RST = 1'b1;
    run_op("post_rst", 32'd1, 32'd1, 1'b0);

    run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op("noovf", 32'd5, 32'd3, 1'b0);
    run_op("rnd", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
